// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined ARM core: PC register, next-PC selection,
// Fetch/Decode pipeline register and saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 BranchTakenE,
    input  logic [31:0]          ALUResultE,
    input  logic                 PCSrcW,
    input  logic [31:0]          ResultW,
    input  logic [31:0]          InstrF,
    input  logic                 CountClr,
    output logic [31:0]          PCF,
    output logic [31:0]          PCPlus4F,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic                 ValidD,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    logic [31:0]          pc_r;
    logic [31:0]          pc_plus4_s;
    logic [31:0]          next_pc_s;
    logic                 redirect_s;
    logic [31:0]          instr_d_r;
    logic [31:0]          pc_d_r;
    logic                 valid_d_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;

    // Counters stick at all-ones so a long run never wraps to a misleading small value.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_WIDTH'(1'b1);
        end
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;
    assign redirect_s = BranchTakenE | PCSrcW;

    // Next-PC select: Execute branch beats Writeback PC write; targets are word-aligned.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (BranchTakenE) begin
            next_pc_s = {ALUResultE[31:2], 2'b00};
        end else if (PCSrcW) begin
            next_pc_s = {ResultW[31:2], 2'b00};
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // PC register: a redirect must land even while Fetch is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (redirect_s || !StallF) begin
            pc_r <= next_pc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Fetch/Decode pipeline register with flush taking priority over stall.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            instr_d_r <= 32'h0000_0000;
            pc_d_r    <= 32'h0000_0000;
            valid_d_r <= 1'b0;
        end else if (StallD) begin
            instr_d_r <= instr_d_r;
            pc_d_r    <= pc_d_r;
            valid_d_r <= valid_d_r;
        end else begin
            instr_d_r <= InstrF;
            pc_d_r    <= pc_r;
            valid_d_r <= 1'b1;
        end
    end

    // Stall event counter; clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || CountClr) begin
            stall_cnt_r <= '0;
        end else if (StallF) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush event counter; clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || CountClr) begin
            flush_cnt_r <= '0;
        end else if (FlushD) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign PCF        = pc_r;
    assign PCPlus4F   = pc_plus4_s;
    assign InstrD     = instr_d_r;
    assign PCD        = pc_d_r;
    assign ValidD     = valid_d_r;
    assign StallCount = stall_cnt_r;
    assign FlushCount = flush_cnt_r;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch stage of the pipelined ARM core, directly upstream of the hazard unit and consumer of its StallF/StallD/FlushD outputs. Holds the PC register, selects the next PC (sequential, branch redirect from Execute, PC write from Writeback), drives the instruction-memory address, and owns the Fetch/Decode pipeline register with stall/flush control. Also keeps saturating stall/flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 16, width of each event counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
StallF  input  1  hold PCF (from hazard unit)
StallD  input  1  hold Fetch/Decode register (from hazard unit)
FlushD  input  1  clear Fetch/Decode register (from hazard unit)
BranchTakenE  input  1  branch resolved taken in Execute
ALUResultE  input  32  branch target from Execute
PCSrcW  input  1  instruction in Writeback writes PC
ResultW  input  32  PC value from Writeback
InstrF  input  32  instruction-memory read data for PCF (combinational)
CountClr  input  1  synchronous clear of both counters
PCF  output  32  current fetch address to instruction memory
PCPlus4F  output  32  PCF + 4 (used as PC+8 in Decode)
InstrD  output  32  Decode-stage instruction
PCD  output  32  Decode-stage PC
ValidD  output  1  InstrD holds a real instruction
StallCount  output  CNT_WIDTH  cycles with StallF=1
FlushCount  output  CNT_WIDTH  cycles with FlushD=1

Behaviour:
- Reset (sync, highest priority): PCF=RESET_PC; InstrD=0, PCD=0, ValidD=0; StallCount=0, FlushCount=0. PCPlus4F = RESET_PC+4 combinationally.
- PCPlus4F = PCF + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Next PC priority: BranchTakenE -> ALUResultE; else PCSrcW -> ResultW; else PCPlus4F. Redirect targets have bits [1:0] forced to 0.
- PCF update: redirect (BranchTakenE or PCSrcW) always loads, overriding StallF; otherwise loads PCPlus4F when StallF=0, holds when StallF=1.
- Fetch/Decode register, priority reset > FlushD > StallD > load:
  - FlushD=1: InstrD=0, PCD=0, ValidD=0 next cycle (flush wins over simultaneous StallD).
  - StallD=1: InstrD, PCD, ValidD hold.
  - else: InstrD<=InstrF, PCD<=PCF, ValidD<=1.
- Latency: instruction at PCF appears on InstrD one cycle later; redirect at edge N fetches target in cycle N+1, target in Decode at N+2.
- Counters: increment by 1 on each edge where the event input is 1; saturate at all-ones (no wrap). CountClr=1 zeroes both, overriding the same-cycle increment. Reset mid-operation clears everything regardless of other inputs.
- No combinational path from InstrF to any output except through the register.

Test Plan:
- Reset then 4 free-running cycles, InstrF=PCF^32'hA5A5_0000 -> PCF 0,4,8,C; InstrD lags one cycle, ValidD=1 from cycle 2, PCD matches prior PCF.
- StallF=StallD=1 for 3 cycles at PCF=8 -> PCF stays 8, InstrD/PCD frozen, StallCount=3.
- BranchTakenE=1, ALUResultE=32'h0000_0103 while StallF=1 -> PCF=32'h0000_0100 next cycle; FlushD=1 same cycle -> ValidD=0, InstrD=0, FlushCount=1.
- BranchTakenE=1 (ALUResultE=0x200) and PCSrcW=1 (ResultW=0x300) together -> PCF=0x200.
- FlushD=1 and StallD=1 same cycle -> ValidD=0; RESET_PC=32'hFFFF_FFFC -> PCPlus4F=0, next PCF=0.
- CNT_WIDTH=2, StallF=1 for 5 cycles -> StallCount 1,2,3,3,3; CountClr=1 with StallF=1 -> 0; reset asserted mid-stall -> all outputs at reset values next cycle.
